// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
//   Drives a memory-mapped UART: holds the device in reset after power-up,
//   then for each accepted message polls the status register until the
//   tx-busy bit clears and writes the next byte to the transmit register.
//   Status polling per byte is bounded; exhausting it aborts the message
//   and raises a sticky timeout flag.
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   start, msg_data     message request (accepted only when idle); byte 0 sent first
//   dev_reset_n         active-low reset to the UART
//   cs_n, rd_n, wr_n    active-low bus strobes (registered)
//   addr, wdata, rdata  bus address, write data, read data (valid cycle after rd)
//   busy, done          not idle; one-cycle message-complete pulse
//   timeout_err         sticky poll-timeout flag
//   byte_idx            index of the byte in progress
module uart_tx_sequencer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned MSG_LEN      = 4,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned TX_ADDR      = 0,
  parameter int unsigned STATUS_ADDR  = 1,
  parameter int unsigned BUSY_BIT     = 0,
  parameter int unsigned POLL_LIMIT   = 255,
  localparam int unsigned IDX_W       = $clog2(MSG_LEN) + 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [MSG_LEN*DATA_WIDTH-1:0] msg_data,
  output logic                          dev_reset_n,
  output logic                          cs_n,
  output logic                          rd_n,
  output logic                          wr_n,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout_err,
  output logic [IDX_W-1:0]              byte_idx
);

  localparam int unsigned RC_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned PC_W = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {RST_HOLD, READY, POLL, CHECK, WRITE, DONE, ERR} state_e;

  state_e                          state_q, state_d;
  logic [RC_W-1:0]                 rst_cnt_q, rst_cnt_d;
  logic [PC_W-1:0]                 poll_cnt_q, poll_cnt_d;
  logic [IDX_W-1:0]                byte_idx_q, byte_idx_d;
  logic [MSG_LEN*DATA_WIDTH-1:0]   msg_q, msg_d;
  logic                            terr_q, terr_d;
  logic                            dev_reset_n_q, dev_reset_n_d;
  logic                            cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
  logic [DATA_WIDTH-1:0]           wdata_q, wdata_d;
  logic                            done_q, done_d;
  logic [DATA_WIDTH-1:0]           byte_sel;
  logic                            unused_rdata;

  // Only the busy bit of the status word is meaningful.
  assign unused_rdata = ^rdata;

  always_comb begin
    byte_sel = '0;
    for (int unsigned i = 0; i < MSG_LEN; i++) begin
      if (byte_idx_q == IDX_W'(i)) byte_sel = msg_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    poll_cnt_d = poll_cnt_q;
    byte_idx_d = byte_idx_q;
    msg_d      = msg_q;
    terr_d     = terr_q;
    case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) state_d = READY;
        else rst_cnt_d = rst_cnt_q + RC_W'(1);
      end
      READY: begin
        if (start) begin
          msg_d      = msg_data;
          byte_idx_d = '0;
          poll_cnt_d = '0;
          terr_d     = 1'b0;
          state_d    = POLL;
        end
      end
      POLL: begin
        poll_cnt_d = poll_cnt_q + PC_W'(1);
        state_d    = CHECK;
      end
      CHECK: begin
        if (rdata[BUSY_BIT]) begin
          state_d = (poll_cnt_q >= PC_W'(POLL_LIMIT)) ? ERR : POLL;
        end else begin
          poll_cnt_d = '0;
          state_d    = WRITE;
        end
      end
      WRITE: begin
        if (byte_idx_q == IDX_W'(MSG_LEN - 1)) begin
          state_d = DONE;
        end else begin
          byte_idx_d = byte_idx_q + IDX_W'(1);
          state_d    = POLL;
        end
      end
      DONE:    state_d = READY;
      ERR: begin
        terr_d  = 1'b1;
        state_d = READY;
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // Bus outputs are registered from the next state so each strobe is low for
  // exactly the cycle spent in POLL/WRITE and is glitch-free.
  always_comb begin
    dev_reset_n_d = (state_d != RST_HOLD);
    rd_n_d        = (state_d != POLL);
    wr_n_d        = (state_d != WRITE);
    cs_n_d        = rd_n_d & wr_n_d;
    done_d        = (state_d == DONE);
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    if (state_d == POLL)  addr_d = ADDR_WIDTH'(STATUS_ADDR);
    if (state_d == WRITE) begin
      addr_d  = ADDR_WIDTH'(TX_ADDR);
      wdata_d = byte_sel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RST_HOLD;
      rst_cnt_q     <= '0;
      poll_cnt_q    <= '0;
      byte_idx_q    <= '0;
      msg_q         <= '0;
      terr_q        <= 1'b0;
      dev_reset_n_q <= 1'b0;
      cs_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      poll_cnt_q    <= poll_cnt_d;
      byte_idx_q    <= byte_idx_d;
      msg_q         <= msg_d;
      terr_q        <= terr_d;
      dev_reset_n_q <= dev_reset_n_d;
      cs_n_q        <= cs_n_d;
      rd_n_q        <= rd_n_d;
      wr_n_q        <= wr_n_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      done_q        <= done_d;
    end
  end

  assign dev_reset_n = dev_reset_n_q;
  assign cs_n        = cs_n_q;
  assign rd_n        = rd_n_q;
  assign wr_n        = wr_n_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign busy        = (state_q != READY);
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign byte_idx    = byte_idx_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
module tb_uart_tx_sequencer;

  localparam int MSG = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] msg_data = '0;
  logic        dev_reset_n, cs_n, rd_n, wr_n, busy, done, timeout_err;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata = '0;
  logic [2:0]  byte_idx;

  // Single-byte instance for the MSG_LEN=1 boundary.
  logic        start1 = 1'b0;
  logic [7:0]  msg1 = '0;
  logic [7:0]  rdata1 = '0;
  logic        dev_reset_n1, cs_n1, rd_n1, wr_n1, busy1, done1, terr1;
  logic [3:0]  addr1;
  logic [7:0]  wdata1;
  logic [0:0]  byte_idx1;

  uart_tx_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .MSG_LEN(MSG), .RESET_CYCLES(16),
    .TX_ADDR(0), .STATUS_ADDR(1), .BUSY_BIT(0), .POLL_LIMIT(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .msg_data(msg_data),
    .dev_reset_n(dev_reset_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .timeout_err(timeout_err), .byte_idx(byte_idx)
  );

  uart_tx_sequencer #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .MSG_LEN(1), .RESET_CYCLES(3),
    .TX_ADDR(0), .STATUS_ADDR(1), .BUSY_BIT(0), .POLL_LIMIT(255)
  ) dut1 (
    .clock(clock), .reset(reset), .start(start1), .msg_data(msg1),
    .dev_reset_n(dev_reset_n1), .cs_n(cs_n1), .rd_n(rd_n1), .wr_n(wr_n1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .busy(busy1), .done(done1),
    .timeout_err(terr1), .byte_idx(byte_idx1)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard state: bytes expected on the bus, status reads expected per
  // byte, and the number of busy status answers still to give per byte.
  logic [7:0] exp_q[$];
  int         exp_reads_q[$];
  int         busy_q[$];
  bit         stuck = 1'b0;
  int         reads_since = 0;
  int         reads_total = 0;
  int         writes_total = 0;

  // Bus slave + monitor.
  always @(negedge clock) begin
    logic [7:0] r;
    check("cs_with_strobe", cs_n, rd_n & wr_n);
    if (!cs_n && !rd_n) begin
      reads_total++;
      reads_since++;
      check("rd_addr", addr, 4'd1);
      check("rd_wr_exclusive", wr_n, 1'b1);
      r = 8'($urandom);
      if (stuck) r[0] = 1'b1;
      else if (busy_q.size() > 0 && busy_q[0] > 0) begin
        r[0] = 1'b1;
        busy_q[0] = busy_q[0] - 1;
      end else r[0] = 1'b0;
      rdata = r;
    end
    if (!cs_n && !wr_n) begin
      writes_total++;
      check("wr_addr", addr, 4'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got wdata %0h expected no write (t=%0t)", wdata, $time);
      end else begin
        check("byte_idx_at_write", byte_idx, 3'(MSG - exp_q.size()));
        check("wdata", wdata, exp_q.pop_front());
        check("reads_per_byte", reads_since, exp_reads_q.pop_front());
      end
      if (busy_q.size() > 0) void'(busy_q.pop_front());
      reads_since = 0;
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 2000) begin
      @(posedge clock); #1;
      k++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  // One message: busy_pat holds 2 bits per byte = number of busy status answers.
  task automatic run_msg(input logic [31:0] data, input logic [7:0] busy_pat, input bit noisy);
    int unsigned t0;
    int sum, b;
    bit got;
    wait_idle();
    sum = 0;
    for (int i = 0; i < MSG; i++) begin
      b = int'(busy_pat[2*i +: 2]);
      exp_q.push_back(data[8*i +: 8]);
      busy_q.push_back(b);
      exp_reads_q.push_back(b + 1);
      sum += b;
    end
    msg_data = data;
    start = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    start = 1'b0;
    if (noisy) msg_data = $urandom;
    check("timeout_cleared_on_start", timeout_err, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock); #1;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (noisy) start = 1'($urandom_range(0, 1));
    end
    start = 1'b0;
    check("done_seen", got, 1'b1);
    if (got) check("done_latency", cyc - t0, 64'(3 * MSG + 2 * sum));
    @(negedge clock); #1;
    check("done_one_cycle", done, 1'b0);
    check("idle_after_done", busy, 1'b0);
    check("all_bytes_written", exp_q.size(), 0);
  endtask

  task automatic release_reset();
    int n;
    @(negedge clock); #1;
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!dev_reset_n && n < 100);
    check("dev_reset_hold_len", n, 16);
    check("ready_after_hold", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0;
    bit saw_done;
    logic [7:0] d1, wd1;
    int w1, bad1;
    int unsigned t1;

    // Reset values.
    #12;
    check("rst_dev_reset_n", dev_reset_n, 1'b0);
    check("rst_busy", busy, 1'b1);
    check("rst_strobes", {cs_n, rd_n, wr_n}, 3'b111);
    check("rst_addr_wdata", {addr, wdata}, 12'h0);
    check("rst_done_terr_idx", {done, timeout_err, byte_idx}, 5'b0);
    release_reset();

    // Directed message, never busy; then byte 1 busy for 3 reads.
    run_msg(32'h44434241, 8'h00, 1'b0);
    run_msg(32'h44434241, 8'h0C, 1'b0);

    // Poll timeout: status stuck busy.
    wait_idle();
    stuck = 1'b1;
    w0 = writes_total;
    r0 = reads_total;
    msg_data = $urandom;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock); #1;
      if (done) saw_done = 1'b1;
      if (!busy) break;
    end
    stuck = 1'b0;
    check("timeout_reads", reads_total - r0, 4);
    check("timeout_no_write", writes_total - w0, 0);
    check("timeout_no_done", saw_done, 1'b0);
    check("timeout_flag", timeout_err, 1'b1);
    repeat (3) @(posedge clock);
    #1 check("timeout_sticky", timeout_err, 1'b1);
    reads_since = 0;

    // Randomized messages with busy polls, start noise and msg_data changes.
    for (int n = 0; n < 15; n++) run_msg($urandom, 8'($urandom), 1'b1);

    // Reset during the second write of a message.
    wait_idle();
    for (int i = 0; i < MSG; i++) begin
      exp_q.push_back(8'(i + 8'h10));
      busy_q.push_back(0);
      exp_reads_q.push_back(1);
    end
    msg_data = 32'h13121110;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    w1 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock); #1;
      if (!wr_n) w1++;
      if (w1 == 2) break;
    end
    check("second_write_reached", w1, 2);
    reset = 1'b1;
    #1;
    check("rst_mid_wr_n", wr_n, 1'b1);
    check("rst_mid_strobes", {cs_n, rd_n}, 2'b11);
    check("rst_mid_dev_reset_n", dev_reset_n, 1'b0);
    check("rst_mid_busy", busy, 1'b1);
    check("rst_mid_idx_addr", {byte_idx, addr, wdata}, 15'h0);
    exp_q.delete();
    busy_q.delete();
    exp_reads_q.delete();
    reads_since = 0;
    w0 = writes_total;
    repeat (3) @(posedge clock);
    release_reset();
    check("no_writes_after_reset", writes_total - w0, 0);
    run_msg($urandom, 8'($urandom), 1'b0);

    // Single-byte instance: byte_idx never moves, 3-cycle transfer.
    for (int n = 0; n < 2; n++) begin
      check("m1_idle", busy1, 1'b0);
      d1 = 8'($urandom);
      msg1 = d1;
      start1 = 1'b1;
      @(posedge clock); #1;
      t1 = cyc;
      start1 = 1'b0;
      msg1 = ~d1;
      w1 = 0;
      bad1 = 0;
      wd1 = '0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clock); #1;
        if (!wr_n1) begin
          w1++;
          wd1 = wdata1;
        end
        if (byte_idx1 != 1'b0) bad1++;
        if (done1) break;
      end
      check("m1_wdata", wd1, d1);
      check("m1_write_count", w1, 1);
      check("m1_byte_idx_static", bad1, 0);
      check("m1_done_latency", cyc - t1, 3);
      @(negedge clock); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
